// File: rtl/mac_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_seq_pkg
// Description : Shared types and constants for the mac_seq operand sequencer.
//               DATA_W   - operand/result width, fixed to match the MAC.
//               SEL_A/B  - operand bank select encodings.
//               seq_state_t - sequencer FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_seq_pkg;

  localparam int DATA_W = 8;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

endpackage : mac_seq_pkg
`default_nettype wire

// File: rtl/mac_seq_operand_rf.sv
`default_nettype none
// ============================================================================
// Module      : operand_rf
// Description : Two DEPTH x DATA_W operand banks (A and B) with one write
//               port and one combinational read port returning the {A,B}
//               pair at a shared index. Banks clear on reset.
// Ports       : clk, reset     - clock, async active-high reset
//               wr_en_i        - write strobe (already qualified by caller)
//               wr_sel_i       - bank select (SEL_A / SEL_B)
//               wr_addr_i      - write index
//               wr_data_i      - write data
//               rd_addr_i      - read index
//               rd_a_o, rd_b_o - A[rd_addr_i], B[rd_addr_i]
// Revision    : 1.0 - initial release
// ============================================================================
module operand_rf
  import mac_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic              wr_sel_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_a_o,
  output logic [DATA_W-1:0] rd_b_o
);

  logic [DATA_W-1:0] bank_a_q [DEPTH];
  logic [DATA_W-1:0] bank_b_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_a_q[i] <= '0;
        bank_b_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      case (wr_sel_i)
        SEL_A: bank_a_q[wr_addr_i] <= wr_data_i;
        SEL_B: bank_b_q[wr_addr_i] <= wr_data_i;
      endcase
    end
  end

  assign rd_a_o = bank_a_q[rd_addr_i];
  assign rd_b_o = bank_b_q[rd_addr_i];

endmodule : operand_rf
`default_nettype wire

// File: rtl/mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : mac_seq
// Description : Dot-product operand sequencer feeding the mac block. Operands
//               are loaded into local A/B banks while idle; an accepted start
//               streams len element pairs into the MAC (accumulate low on the
//               first pair), waits one cycle for the MAC register, then
//               captures mac_in as result with a one-cycle done pulse.
// Ports       : clk, reset              - clock, async active-high reset
//               wr_en/wr_sel/wr_addr/wr_data - bank write port (idle only)
//               start, len              - command; len legal in 1..DEPTH
//               busy                    - run in progress
//               err                     - pulse on rejected start
//               mac_a, mac_b, mac_acc   - MAC operand/accumulate drive
//               mac_in                  - MAC output
//               result, done            - captured dot product and strobe
// Revision    : 1.0 - initial release
// ============================================================================
module mac_seq
  import mac_seq_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [AW:0]       len,
  output logic              busy,
  output logic              err,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic              mac_acc,
  input  logic [DATA_W-1:0] mac_in,
  output logic [DATA_W-1:0] result,
  output logic              done
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  seq_state_t        state_q,   state_d;
  logic [AW-1:0]     idx_q,     idx_d;
  logic [AW:0]       len_q,     len_d;
  logic [DATA_W-1:0] mac_a_q,   mac_a_d;
  logic [DATA_W-1:0] mac_b_q,   mac_b_d;
  logic              mac_acc_q, mac_acc_d;
  logic              err_q,     err_d;
  logic              done_q,    done_d;
  logic [DATA_W-1:0] result_q,  result_d;

  logic              rf_wr_en;
  logic [AW-1:0]     rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_a;
  logic [DATA_W-1:0] rf_rd_b;

  // Bank writes only land while idle; a write during a run is dropped.
  assign rf_wr_en = wr_en && (state_q == IDLE);

  // Idle: element 0 is presented for a possible accept. Issue: look one
  // element ahead (the wrap on the final element is never used).
  assign rf_rd_addr = (state_q == ISSUE) ? idx_q + 1'b1 : '0;

  operand_rf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rf (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (rf_wr_en),
    .wr_sel_i  (wr_sel),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (rf_rd_addr),
    .rd_a_o    (rf_rd_a),
    .rd_b_o    (rf_rd_b)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      mac_a_q   <= '0;
      mac_b_q   <= '0;
      mac_acc_q <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      mac_a_q   <= mac_a_d;
      mac_b_q   <= mac_b_d;
      mac_acc_q <= mac_acc_d;
      err_q     <= err_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    // Operands default to zero so the MAC settles to 0 outside a run.
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    mac_a_d   = '0;
    mac_b_d   = '0;
    mac_acc_d = 1'b0;
    err_d     = 1'b0;
    done_d    = 1'b0;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (!wr_en && (len != '0) && (len <= DEPTH_L)) begin
            len_d   = len;
            idx_d   = '0;
            mac_a_d = rf_rd_a;
            mac_b_d = rf_rd_b;
            state_d = ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ISSUE: begin
        if ({1'b0, idx_q} == (len_q - 1'b1)) begin
          state_d = DRAIN;
        end else begin
          idx_d     = idx_q + 1'b1;
          mac_a_d   = rf_rd_a;
          mac_b_d   = rf_rd_b;
          mac_acc_d = 1'b1;
        end
      end

      DRAIN: begin
        // The MAC register has absorbed the last pair; mac_in is the sum.
        result_d = mac_in;
        done_d   = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign err     = err_q;
  assign mac_a   = mac_a_q;
  assign mac_b   = mac_b_q;
  assign mac_acc = mac_acc_q;
  assign result  = result_q;
  assign done    = done_q;

endmodule : mac_seq
`default_nettype wire

// File: tb/tb_mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_seq
// Description : Self-checking bench for mac_seq with a behavioural MAC
//               attached. Expected dot products are queued when a start is
//               driven and compared when done is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_seq;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic       wr_sel;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic [4:0] len;
  logic       busy;
  logic       err;
  logic [7:0] mac_a;
  logic [7:0] mac_b;
  logic       mac_acc;
  logic [7:0] mac_q;
  logic [7:0] result;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sa [DEPTH];
  logic [7:0] sb [DEPTH];
  logic [7:0] sb_q [$];

  always #5 clk = ~clk;

  // Behavioural MAC: registered, 8-bit truncating multiply-accumulate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        mac_q <= 8'd0;
    else if (mac_acc) mac_q <= mac_q + mac_a * mac_b;
    else              mac_q <= mac_a * mac_b;
  end

  mac_seq #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .len     (len),
    .busy    (busy),
    .err     (err),
    .mac_a   (mac_a),
    .mac_b   (mac_b),
    .mac_acc (mac_acc),
    .mac_in  (mac_q),
    .result  (result),
    .done    (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input int addr, input int data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = addr[3:0];
    wr_data = data[7:0];
    tick();
    wr_en = 1'b0;
    if (sel) sb[addr] = data[7:0];
    else     sa[addr] = data[7:0];
  endtask

  // Rejected start; optionally with a simultaneous write of A[0].
  task automatic bad_start(input int n, input bit we, input int wdata);
    start   = 1'b1;
    len     = n[4:0];
    wr_en   = we;
    wr_sel  = 1'b0;
    wr_addr = 4'd0;
    wr_data = wdata[7:0];
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    if (we) sa[0] = wdata[7:0];
    check("err_pulse", err, 1'b1);
    check("err_no_busy", busy, 1'b0);
    tick();
    check("err_clear", err, 1'b0);
    check("err_idle", busy, 1'b0);
  endtask

  // Full run. inj >= 0 drives a start plus a write of A[3]=99 in that cycle.
  task automatic do_run(input int n, input logic [7:0] exp, input int inj);
    bit seen;
    logic [7:0] want;
    seen  = 1'b0;
    start = 1'b1;
    len   = n[4:0];
    sb_q.push_back(exp);
    tick();
    start = 1'b0;
    len   = 5'd0;
    for (int k = 0; k <= n + 4 && !seen; k++) begin
      if (k == inj) begin
        start = 1'b1; len = 5'd3;
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd3; wr_data = 8'd99;
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      check("no_err", err, 1'b0);
      if (k < n) begin
        check("busy_run", busy, 1'b1);
        check("done_early", done, 1'b0);
        check("mac_acc", mac_acc, (k != 0));
        check("mac_a", mac_a, sa[k]);
        check("mac_b", mac_b, sb[k]);
      end else if (k == n) begin
        check("busy_drain", busy, 1'b1);
        check("done_drain", done, 1'b0);
        check("drain_acc", mac_acc, 1'b0);
        check("drain_a", mac_a, 8'd0);
      end else if (done) begin
        seen = 1'b1;
        want = sb_q.pop_front();
        check("latency", k, n + 1);
        check("result", result, want);
        check("busy_done", busy, 1'b0);
      end
      if (!seen) tick();
    end
    start = 1'b0;
    wr_en = 1'b0;
    if (!seen) begin
      check("done_timeout", done, 1'b1);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; len = '0;
    for (int i = 0; i < DEPTH; i++) begin sa[i] = 8'd0; sb[i] = 8'd0; end
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_acc", mac_acc, 1'b0);
    check("rst_a", mac_a, 8'd0);
    check("rst_b", mac_b, 8'd0);
    check("rst_result", result, 8'd0);
    reset = 1'b0;
    tick();

    // Basic dot product
    for (int i = 0; i < 4; i++) begin wr(1'b0, i, i + 1); wr(1'b1, i, i + 5); end
    do_run(4, 8'd70, -1);

    // Wrap-around
    for (int i = 0; i < 2; i++) begin wr(1'b0, i, 15); wr(1'b1, i, 15); end
    do_run(2, 8'd194, -1);

    // Illegal starts; the last also writes A[0]=200
    wr(1'b1, 0, 2);
    bad_start(0, 1'b0, 0);
    bad_start(DEPTH + 1, 1'b0, 0);
    bad_start(1, 1'b1, 200);
    do_run(1, 8'd144, -1);

    // Busy protection: start + write A[3]=99 mid-run must be dropped
    for (int i = 0; i < 8; i++) begin wr(1'b0, i, i + 1); wr(1'b1, i, 2); end
    do_run(8, 8'd72, 2);
    do_run(8, 8'd72, -1);

    // Reset during ISSUE (cycle 2 of a len=6 run)
    start = 1'b1; len = 5'd6;
    tick();
    start = 1'b0; len = 5'd0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("mrst_busy", busy, 1'b0);
    check("mrst_a", mac_a, 8'd0);
    check("mrst_b", mac_b, 8'd0);
    check("mrst_acc", mac_acc, 1'b0);
    check("mrst_result", result, 8'd0);
    check("mrst_err", err, 1'b0);
    check("mrst_done", done, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin sa[i] = 8'd0; sb[i] = 8'd0; end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("mrst_no_done", done, 1'b0);
    end

    // Reload all ones, run len=6, then back-to-back len=DEPTH
    for (int i = 0; i < DEPTH; i++) begin wr(1'b0, i, 1); wr(1'b1, i, 1); end
    do_run(6, 8'd6, -1);
    do_run(DEPTH, 8'd16, -1);

    check("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_mac_seq
`default_nettype wire
